// File: rtl/nlprg_n.sv
// N-bit de Bruijn-corrected Fibonacci LFSR: full 2^N period including the all-zero state.
// Build with NLPRG_PERIOD_CHECK_EN defined to add the advance counter and sticky err output.
module nlprg_n #(
    parameter int unsigned N = 7
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ld,
    input  logic [N-1:0] seed,
    output logic [N-1:0] o,
    output logic         wrap
`ifdef NLPRG_PERIOD_CHECK_EN
    ,
    output logic         err
`endif
);

    generate
        if (N < 3 || N > 16) begin : g_bad_n
            $error("nlprg_n: N must be in the range 3..16");
        end
    endgenerate

    // Bit t-1 set for each 1-indexed tap t.
    function automatic logic [15:0] tap_mask(input int unsigned n);
        case (n)
            3:       tap_mask = 16'h0006;
            4:       tap_mask = 16'h000C;
            5:       tap_mask = 16'h0014;
            6:       tap_mask = 16'h0030;
            7:       tap_mask = 16'h0060;
            8:       tap_mask = 16'h00B8;
            9:       tap_mask = 16'h0110;
            10:      tap_mask = 16'h0240;
            11:      tap_mask = 16'h0500;
            12:      tap_mask = 16'h0829;
            13:      tap_mask = 16'h100D;
            14:      tap_mask = 16'h2015;
            15:      tap_mask = 16'h6000;
            16:      tap_mask = 16'hD008;
            default: tap_mask = 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]  MASK16 = tap_mask(N);
    localparam logic [N-1:0] TAPS   = MASK16[N-1:0];

    logic [N-1:0] s;
    logic [N-1:0] ref_s;
    logic [N-1:0] s_next;
    logic         fb;
    logic         wrap_q;

    // The zero-detect term splices 0 into the cycle between {1,0..0} and 1.
    always_comb begin
        fb     = (^(s & TAPS)) ^ (s[N-2:0] == '0);
        s_next = {s[N-2:0], fb};
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '0;
            ref_s  <= '0;
            wrap_q <= 1'b0;
        end else if (ld) begin
            s      <= seed;
            ref_s  <= seed;
            wrap_q <= 1'b0;
        end else if (en) begin
            s      <= s_next;
            wrap_q <= (s_next == ref_s);
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign o    = s;
    assign wrap = wrap_q;

`ifdef NLPRG_PERIOD_CHECK_EN
    logic [N-1:0] cnt;
    logic [N-1:0] cnt_inc;
    logic         err_q;

    assign cnt_inc = cnt + N'(1);

    // A return to ref must coincide exactly with the counter rolling over.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (ld) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc;
            if ((s_next == ref_s) != (cnt_inc == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_nlprg_n.sv
// Self-checking bench for nlprg_n: instances at N=3, 7 and 16 with a per-cycle scoreboard.
module tb_nlprg_n;

    logic        ck = 1'b0;
    logic        rst_n;
    logic        en3, ld3, wrap3;
    logic [2:0]  seed3, o3;
    logic        en7, ld7, wrap7;
    logic [6:0]  seed7, o7;
    logic        en16, ld16, wrap16;
    logic [15:0] seed16, o16;
`ifdef NLPRG_PERIOD_CHECK_EN
    logic        err3, err7, err16;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] o;
        logic        w;
    } exp_t;

    exp_t       sb3[$];
    exp_t       sb7[$];
    logic [6:0] m7_o;
    logic [6:0] m7_ref;
    bit         seen7[128];
    bit         seen16[65536];

    always #5 ck = ~ck;

    nlprg_n #(.N(3)) u_n3 (
        .ck(ck), .rst_n(rst_n), .en(en3), .ld(ld3), .seed(seed3), .o(o3), .wrap(wrap3)
`ifdef NLPRG_PERIOD_CHECK_EN
        , .err(err3)
`endif
    );

    nlprg_n #(.N(7)) u_n7 (
        .ck(ck), .rst_n(rst_n), .en(en7), .ld(ld7), .seed(seed7), .o(o7), .wrap(wrap7)
`ifdef NLPRG_PERIOD_CHECK_EN
        , .err(err7)
`endif
    );

    nlprg_n #(.N(16)) u_n16 (
        .ck(ck), .rst_n(rst_n), .en(en16), .ld(ld16), .seed(seed16), .o(o16), .wrap(wrap16)
`ifdef NLPRG_PERIOD_CHECK_EN
        , .err(err16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference step built from explicit tap lists.
    function automatic logic [15:0] ref_next(input logic [15:0] s, input int n);
        int          taps[$];
        logic        fb;
        logic        zero;
        logic [15:0] r;
        case (n)
            3:       taps = '{3, 2};
            7:       taps = '{7, 6};
            default: taps = '{16, 15, 13, 4};
        endcase
        fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]-1];
        zero = 1'b1;
        for (int b = 0; b < n - 1; b++) if (s[b]) zero = 1'b0;
        r = {s[14:0], fb ^ zero};
        for (int b = n; b < 16; b++) r[b] = 1'b0;
        return r;
    endfunction

    task automatic chk_err(input string tag);
`ifdef NLPRG_PERIOD_CHECK_EN
        chk(tag, {29'b0, err3, err7, err16}, 32'd0);
`else
        chk(tag, {29'b0, wrap3 & 1'b0, 2'b00}, {31'b0, en3 & 1'b0});
`endif
    endtask

    task automatic adv3(input logic [2:0] eo, input logic ew);
        exp_t x;
        x.o = {13'b0, eo};
        x.w = ew;
        sb3.push_back(x);
        en3 = 1'b1;
        @(posedge ck); #1;
        en3 = 1'b0;
        x = sb3.pop_front();
        chk("o3", 32'(o3), 32'(x.o));
        chk("wrap3", 32'(wrap3), 32'(x.w));
    endtask

    task automatic cyc7(input logic e, input logic l, input logic [6:0] sd);
        exp_t        x;
        logic [15:0] nx;
        x.w = 1'b0;
        if (l) begin
            m7_o   = sd;
            m7_ref = sd;
        end else if (e) begin
            nx   = ref_next({9'b0, m7_o}, 7);
            m7_o = nx[6:0];
            x.w  = (m7_o == m7_ref);
        end
        x.o = {9'b0, m7_o};
        sb7.push_back(x);
        en7 = e; ld7 = l; seed7 = sd;
        @(posedge ck); #1;
        en7 = 1'b0; ld7 = 1'b0;
        x = sb7.pop_front();
        chk("o7", 32'(o7), 32'(x.o));
        chk("wrap7", 32'(wrap7), 32'(x.w));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        @(posedge ck); #1;
        rst_n  = 1'b1;
        m7_o   = '0;
        m7_ref = '0;
    endtask

    initial begin
        int          wcnt, dup, widx, nseen;
        logic [2:0]  seq3[8];
        seq3 = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0};

        rst_n = 1'b0;
        en3 = 0; ld3 = 0; seed3 = '0;
        en7 = 0; ld7 = 0; seed7 = '0;
        en16 = 0; ld16 = 0; seed16 = '0;
        m7_o = '0; m7_ref = '0;
        @(posedge ck); #1;
        chk("rst_o", {o3, o7, o16}, 32'd0);
        chk("rst_wrap", {29'b0, wrap3, wrap7, wrap16}, 32'd0);
        chk_err("rst_err");
        rst_n = 1'b1;

        // N=3 full cycle back to 0 with one wrap
        for (int i = 0; i < 8; i++) adv3(seq3[i], i == 7);
        chk("n3_wrap_hi", 32'(wrap3), 32'd1);
        chk_err("n3_err");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wrap3", 32'(wrap3), 32'd0);
        chk("async_rst_o3", 32'(o3), 32'd0);
        @(posedge ck); #1;
        rst_n = 1'b1;

        // en toggled 1,0,0,1
        cyc7(1, 0, '0); cyc7(0, 0, '0); cyc7(0, 0, '0); cyc7(1, 0, '0);
        chk("toggle_o7", 32'(o7), 32'd2);

        // 256 advances: 128 distinct states, wraps at 128 and 256
        do_reset();
        seen7 = '{default: 1'b0};
        wcnt = 0; dup = 0;
        for (int i = 1; i <= 256; i++) begin
            cyc7(1, 0, '0);
            if (i <= 128) begin
                if (seen7[o7]) dup++;
                seen7[o7] = 1'b1;
            end
            if (wrap7) begin
                wcnt++;
                chk("wrap7_idx", 32'(i), 32'(128 * wcnt));
            end
        end
        nseen = 0;
        foreach (seen7[k]) if (seen7[k]) nseen++;
        chk("distinct7", 32'(nseen), 32'd128);
        chk("dup7", 32'(dup), 32'd0);
        chk("wraps7", 32'(wcnt), 32'd2);
        chk_err("n7_err");

        // seed load then a full period
        cyc7(0, 1, 7'h55);
        chk("ld_wrap7", 32'(wrap7), 32'd0);
        wcnt = 0;
        for (int i = 1; i <= 128; i++) begin
            cyc7(1, 0, '0);
            if (wrap7) begin
                wcnt++;
                chk("ld_wrap7_idx", 32'(i), 32'd128);
            end
        end
        chk("ld_final_o7", 32'(o7), 32'h55);
        chk("ld_final_wrap7", 32'(wrap7), 32'd1);
        chk("ld_wraps7", 32'(wcnt), 32'd1);

        // ld beats en; reloading seed == ref never wraps
        cyc7(1, 1, 7'h12);
        chk("ld_en_o7", 32'(o7), 32'h12);
        cyc7(0, 1, 7'h12);
        chk("ld_same_wrap7", 32'(wrap7), 32'd0);
        chk_err("ld_err");

        // asynchronous reset mid-period
        do_reset();
        for (int i = 0; i < 50; i++) cyc7(1, 0, '0);
        chk("mid_nonzero", 32'(o7 != '0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_o7", 32'(o7), 32'd0);
        chk("mid_rst_wrap7", 32'(wrap7), 32'd0);
        chk_err("mid_rst_err");
        @(posedge ck); #1;
        rst_n = 1'b1;
        m7_o = '0; m7_ref = '0;
        wcnt = 0;
        for (int i = 1; i <= 128; i++) begin
            cyc7(1, 0, '0);
            if (wrap7) begin
                wcnt++;
                chk("mid_wrap7_idx", 32'(i), 32'd128);
            end
        end
        chk("mid_wraps7", 32'(wcnt), 32'd1);
        chk("mid_final_o7", 32'(o7), 32'd0);

        // N=16 full period
        do_reset();
        seen16 = '{default: 1'b0};
        wcnt = 0; dup = 0; widx = 0;
        en16 = 1'b1;
        for (int i = 1; i <= 65536; i++) begin
            @(posedge ck); #1;
            if (seen16[o16]) dup++;
            seen16[o16] = 1'b1;
            if (wrap16) begin
                wcnt++;
                widx = i;
            end
        end
        en16 = 1'b0;
        chk("wraps16", 32'(wcnt), 32'd1);
        chk("wrap16_idx", 32'(widx), 32'd65536);
        chk("dup16", 32'(dup), 32'd0);
        chk("final_o16", 32'(o16), 32'd0);
        chk_err("n16_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
